// File: rtl/ahb3lite_sdram_ctrl_pkg.sv
// Shared types and helpers for the AHB3-Lite SDRAM controller.
package ahb3lite_sdram_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StRefresh = 2'd2
  } arb_state_t;

  // Index width with a floor of one bit so single-port builds still have an id.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb3lite_sdram_arbiter_if.sv
// Request/grant bundle between AHB port front-ends, refresh timer and the SDRAM arbiter.
interface ahb3lite_sdram_arbiter_if
  import ahb3lite_sdram_ctrl_pkg::*;
#(
  parameter int unsigned PORTS   = 4,
  parameter int unsigned RFR_MAX = 7
);
  localparam int unsigned IdW   = idx_width(PORTS);
  localparam int unsigned PendW = $clog2(RFR_MAX + 1);

  logic [PORTS-1:0] req_i;
  logic [PORTS-1:0] lock_i;
  logic             done_i;
  logic             rfr_req_i;
  logic [PORTS-1:0] gnt_o;
  logic [IdW-1:0]   gnt_id_o;
  logic             start_o;
  logic             rfr_start_o;
  logic [PendW-1:0] rfr_pend_o;
  logic             rfr_ovf_o;
  logic             busy_o;

  modport slave (
    input  req_i, lock_i, done_i, rfr_req_i,
    output gnt_o, gnt_id_o, start_o, rfr_start_o, rfr_pend_o, rfr_ovf_o, busy_o
  );

  modport master (
    output req_i, lock_i, done_i, rfr_req_i,
    input  gnt_o, gnt_id_o, start_o, rfr_start_o, rfr_pend_o, rfr_ovf_o, busy_o
  );

endinterface

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1, wrapping.
module sdram_rr_pick
  import ahb3lite_sdram_ctrl_pkg::*;
#(
  parameter int unsigned PORTS = 4,
  parameter int unsigned IdW   = idx_width(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IdW-1:0]   last,
  output logic [PORTS-1:0] gnt,
  output logic [IdW-1:0]   id,
  output logic             any
);

  logic [IdW-1:0] w_idx;

  always_comb begin
    gnt   = '0;
    id    = '0;
    any   = 1'b0;
    w_idx = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      w_idx = IdW'((32'(last) + 32'd1 + i) % PORTS);
      if (!any && req[w_idx]) begin
        any        = 1'b1;
        gnt[w_idx] = 1'b1;
        id         = w_idx;
      end
    end
  end

endmodule

// File: rtl/ahb3lite_sdram_arbiter.sv
// Grants the SDRAM command path to one AHB port or the refresh timer at a time.
module ahb3lite_sdram_arbiter
  import ahb3lite_sdram_ctrl_pkg::*;
#(
  parameter int unsigned PORTS      = 4,
  parameter int unsigned RFR_MAX    = 7,
  parameter int unsigned RFR_URGENT = 4
) (
  input logic                     HCLK,
  input logic                     HRESETn,
  ahb3lite_sdram_arbiter_if.slave bus
);

  localparam int unsigned IdW   = idx_width(PORTS);
  localparam int unsigned PendW = $clog2(RFR_MAX + 1);

  localparam logic [IdW-1:0]   LastRst   = IdW'(PORTS - 1);
  localparam logic [PendW-1:0] MaxCnt    = PendW'(RFR_MAX);
  localparam logic [PendW-1:0] UrgentCnt = PendW'(RFR_URGENT);

  arb_state_t       r_state, w_state_d;
  logic [IdW-1:0]   r_last, w_last_d;
  logic [PORTS-1:0] r_gnt, w_gnt_d;
  logic [IdW-1:0]   r_gnt_id, w_gnt_id_d;
  logic             r_start, w_start_d;
  logic             r_rfr_start, w_rfr_start_d;
  logic [PendW-1:0] r_pend, w_pend_d;
  logic             r_ovf, w_ovf_d;

  logic [PORTS-1:0] w_pick_gnt;
  logic [IdW-1:0]   w_pick_id;
  logic             w_pick_any;
  logic             w_relock;

  sdram_rr_pick #(
    .PORTS (PORTS),
    .IdW   (IdW)
  ) u_pick (
    .req  (bus.req_i),
    .last (r_last),
    .gnt  (w_pick_gnt),
    .id   (w_pick_id),
    .any  (w_pick_any)
  );

  // Locked owner keeps the path unless refreshes are piling up.
  assign w_relock = bus.lock_i[r_gnt_id] & bus.req_i[r_gnt_id] & (r_pend < UrgentCnt);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state     <= StIdle;
      r_last      <= LastRst;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_start     <= 1'b0;
      r_rfr_start <= 1'b0;
      r_pend      <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_last      <= w_last_d;
      r_gnt       <= w_gnt_d;
      r_gnt_id    <= w_gnt_id_d;
      r_start     <= w_start_d;
      r_rfr_start <= w_rfr_start_d;
      r_pend      <= w_pend_d;
      r_ovf       <= w_ovf_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (r_pend != '0)    w_state_d = StRefresh;
        else if (w_pick_any) w_state_d = StGrant;
      end
      StGrant:   if (bus.done_i && !w_relock) w_state_d = StIdle;
      StRefresh: if (bus.done_i) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_gnt_d       = r_gnt;
    w_gnt_id_d    = r_gnt_id;
    w_last_d      = r_last;
    w_start_d     = 1'b0;
    w_rfr_start_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_pend != '0) begin
          w_rfr_start_d = 1'b1;
        end else if (w_pick_any) begin
          w_gnt_d    = w_pick_gnt;
          w_gnt_id_d = w_pick_id;
          w_last_d   = w_pick_id;
          w_start_d  = 1'b1;
        end
      end
      StGrant: begin
        if (bus.done_i) begin
          if (w_relock) begin
            w_start_d = 1'b1;
          end else begin
            w_gnt_d    = '0;
            w_gnt_id_d = '0;
          end
        end
      end
      default: ;
    endcase

    // A request and a start in the same cycle cancel out.
    w_pend_d = r_pend;
    w_ovf_d  = r_ovf;
    if (bus.rfr_req_i && !w_rfr_start_d) begin
      if (r_pend == MaxCnt) w_ovf_d  = 1'b1;
      else                  w_pend_d = r_pend + 1'b1;
    end else if (!bus.rfr_req_i && w_rfr_start_d) begin
      w_pend_d = r_pend - 1'b1;
    end
  end

  assign bus.gnt_o       = r_gnt;
  assign bus.gnt_id_o    = r_gnt_id;
  assign bus.start_o     = r_start;
  assign bus.rfr_start_o = r_rfr_start;
  assign bus.rfr_pend_o  = r_pend;
  assign bus.rfr_ovf_o   = r_ovf;
  assign bus.busy_o      = (r_state != StIdle);

endmodule

// File: tb/tb_ahb3lite_sdram_arbiter.sv
// Directed bench for the SDRAM arbiter: vector table plus lock/refresh/reset sequences.
module tb_ahb3lite_sdram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahb3lite_sdram_arbiter_if #(.PORTS(4), .RFR_MAX(7)) bus ();

  ahb3lite_sdram_arbiter #(
    .PORTS      (4),
    .RFR_MAX    (7),
    .RFR_URGENT (4)
  ) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic       done;
    logic       rfr;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       start;
    logic       rfs;
    logic [2:0] pend;
    logic       busy;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] gnt, input logic start,
                         input logic rfs, input logic [2:0] pend, input logic busy);
    chk(name, 32'({bus.gnt_o, bus.start_o, bus.rfr_start_o, bus.rfr_pend_o, bus.busy_o}),
        32'({gnt, start, rfs, pend, busy}));
  endtask

  task automatic add(input logic [3:0] req, input logic [3:0] lock, input logic done,
                     input logic rfr, input logic [3:0] gnt, input logic [1:0] id,
                     input logic start, input logic rfs, input logic [2:0] pend,
                     input logic busy);
    vec_t v;
    v.req = req; v.lock = lock; v.done = done; v.rfr = rfr;
    v.gnt = gnt; v.id = id; v.start = start; v.rfs = rfs; v.pend = pend; v.busy = busy;
    vq.push_back(v);
  endtask

  // Drive one cycle of inputs, then sample just after the edge that consumes them.
  task automatic step(input logic [3:0] req, input logic [3:0] lock, input logic done,
                      input logic rfr);
    bus.req_i     = req;
    bus.lock_i    = lock;
    bus.done_i    = done;
    bus.rfr_req_i = rfr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(4'h0, 4'h0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req_i = '0; bus.lock_i = '0; bus.done_i = 1'b0; bus.rfr_req_i = 1'b0;

    // Round-robin 0,1,2,3 with a bubble after each release.
    for (int k = 0; k < 4; k++) begin
      add(4'hF, 4'h0, 1'b0, 1'b0, 4'(1 << k), 2'(k), 1'b1, 1'b0, 3'd0, 1'b1);
      add(4'hF, 4'h0, 1'b0, 1'b0, 4'(1 << k), 2'(k), 1'b0, 1'b0, 3'd0, 1'b1);
      add(4'hF, 4'h0, 1'b0, 1'b0, 4'(1 << k), 2'(k), 1'b0, 1'b0, 3'd0, 1'b1);
      add(4'hF, 4'h0, 1'b1, 1'b0, 4'h0,       2'd0,  1'b0, 1'b0, 3'd0, 1'b0);
    end
    // Wrap back to 0, refresh arrives mid-grant and beats the waiting ports.
    add(4'hF, 4'h0, 1'b0, 1'b0, 4'h1, 2'd0, 1'b1, 1'b0, 3'd0, 1'b1);
    add(4'hF, 4'h0, 1'b0, 1'b1, 4'h1, 2'd0, 1'b0, 1'b0, 3'd1, 1'b1);
    add(4'hF, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 3'd1, 1'b0);
    add(4'hF, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 3'd0, 1'b1);
    add(4'hF, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b1);
    add(4'hF, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    add(4'hF, 4'h0, 1'b0, 1'b0, 4'h2, 2'd1, 1'b1, 1'b0, 3'd0, 1'b1);
    add(4'hF, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    // done in IDLE is ignored.
    add(4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    add(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    // Port 2 after last=1; owner drops req and non-owners toggle: grant stays.
    add(4'h4, 4'h0, 1'b0, 1'b0, 4'h4, 2'd2, 1'b1, 1'b0, 3'd0, 1'b1);
    add(4'hB, 4'hB, 1'b0, 1'b0, 4'h4, 2'd2, 1'b0, 1'b0, 3'd0, 1'b1);
    add(4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);

    do_reset();
    chk_out("reset_outputs", 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("reset_id", 32'(bus.gnt_id_o), 32'd0);
    chk("reset_ovf", 32'(bus.rfr_ovf_o), 32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].req, vq[i].lock, vq[i].done, vq[i].rfr);
      chk_out($sformatf("vec%0d", i), vq[i].gnt, vq[i].start, vq[i].rfs, vq[i].pend,
              vq[i].busy);
      if (vq[i].gnt != 4'h0) chk($sformatf("vec%0d_id", i), 32'(bus.gnt_id_o), 32'(vq[i].id));
    end

    // Lock: port 2 keeps the grant through three done pulses.
    do_reset();
    step(4'h4, 4'h4, 1'b0, 1'b0);
    chk_out("lock_first", 4'h4, 1'b1, 1'b0, 3'd0, 1'b1);
    chk("lock_first_id", 32'(bus.gnt_id_o), 32'd2);
    for (int t = 0; t < 3; t++) begin
      step(4'h7, 4'h4, 1'b0, 1'b0);
      chk_out($sformatf("lock_hold%0d", t), 4'h4, 1'b0, 1'b0, 3'd0, 1'b1);
      step(4'h7, 4'h4, 1'b1, 1'b0);
      chk_out($sformatf("lock_regrant%0d", t), 4'h4, 1'b1, 1'b0, 3'd0, 1'b1);
    end
    step(4'h7, 4'h0, 1'b1, 1'b0);
    chk_out("lock_release", 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    step(4'h7, 4'h0, 1'b0, 1'b0);
    chk_out("lock_next", 4'h1, 1'b1, 1'b0, 3'd0, 1'b1);
    chk("lock_next_id", 32'(bus.gnt_id_o), 32'd0);

    // Urgent refresh: re-grant below 4 pending, refused at 4, then drain.
    do_reset();
    step(4'h1, 4'h1, 1'b0, 1'b0);
    chk_out("urg_grant", 4'h1, 1'b1, 1'b0, 3'd0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step(4'h1, 4'h1, 1'b0, 1'b1);
      chk_out($sformatf("urg_pend%0d", k), 4'h1, 1'b0, 1'b0, 3'(k), 1'b1);
    end
    step(4'h1, 4'h1, 1'b1, 1'b0);
    chk_out("urg_regrant_at3", 4'h1, 1'b1, 1'b0, 3'd3, 1'b1);
    step(4'h1, 4'h1, 1'b0, 1'b1);
    chk_out("urg_pend4", 4'h1, 1'b0, 1'b0, 3'd4, 1'b1);
    step(4'h1, 4'h1, 1'b1, 1'b0);
    chk_out("urg_lock_broken", 4'h0, 1'b0, 1'b0, 3'd4, 1'b0);
    for (int k = 4; k >= 1; k--) begin
      // Last drain step also raises a new request: the count must hold at 1.
      step(4'h1, 4'h1, 1'b0, (k == 1));
      chk_out($sformatf("urg_rfs%0d", k), 4'h0, 1'b0, 1'b1, (k == 1) ? 3'd1 : 3'(k - 1), 1'b1);
      step(4'h1, 4'h1, 1'b1, 1'b0);
      chk_out($sformatf("urg_rdone%0d", k), 4'h0, 1'b0, 1'b0, (k == 1) ? 3'd1 : 3'(k - 1),
              1'b0);
    end
    step(4'h1, 4'h1, 1'b0, 1'b0);
    chk_out("urg_rfs_extra", 4'h0, 1'b0, 1'b1, 3'd0, 1'b1);
    step(4'h1, 4'h1, 1'b1, 1'b0);
    chk_out("urg_rdone_extra", 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    step(4'h1, 4'h1, 1'b0, 1'b0);
    chk_out("urg_port_after", 4'h1, 1'b1, 1'b0, 3'd0, 1'b1);
    chk("urg_no_ovf", 32'(bus.rfr_ovf_o), 32'd0);

    // Saturation while done is withheld.
    do_reset();
    step(4'h1, 4'h0, 1'b0, 1'b0);
    chk_out("sat_grant", 4'h1, 1'b1, 1'b0, 3'd0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step(4'h1, 4'h0, 1'b0, 1'b1);
      chk_out($sformatf("sat_pend%0d", k), 4'h1, 1'b0, 1'b0, (k >= 7) ? 3'd7 : 3'(k), 1'b1);
      chk($sformatf("sat_ovf%0d", k), 32'(bus.rfr_ovf_o), (k == 8) ? 32'd1 : 32'd0);
    end

    // Reset mid-grant clears everything and restores last so port 0 wins ties.
    rst_n = 1'b0;
    step(4'hF, 4'h0, 1'b0, 1'b0);
    chk_out("rst_mid_outputs", 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("rst_mid_ovf", 32'(bus.rfr_ovf_o), 32'd0);
    rst_n = 1'b1;
    step(4'hF, 4'h0, 1'b0, 1'b0);
    chk_out("rst_tie", 4'h1, 1'b1, 1'b0, 3'd0, 1'b1);
    chk("rst_tie_id", 32'(bus.gnt_id_o), 32'd0);
    step(4'h0, 4'h0, 1'b1, 1'b0);
    chk_out("rst_release", 4'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    step(4'h8, 4'h0, 1'b0, 1'b0);
    chk_out("rst_port3", 4'h8, 1'b1, 1'b0, 3'd0, 1'b1);
    chk("rst_port3_id", 32'(bus.gnt_id_o), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
